// File: rtl/pc_fetch_if.sv
// pc_fetch_if
//   Bundles every non-clock signal of pc_fetch_unit: the next-PC/control
//   inputs, the instruction-memory req/ack bus and the decode valid/ready
//   handshake.
//   master : the fetch unit side (drives pc_o, imem_*, inst_*, error pulses).
//   slave  : the surrounding core / memory / decode side.
interface pc_fetch_if;
    logic [31:0] npc_i;
    logic        pc_we;
    logic        flush;
    logic [31:0] pc_o;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst_o;
    logic        inst_valid;
    logic        inst_ready;
    logic        misalign_err;
    logic        fetch_err;

    modport master (
        input  npc_i, pc_we, flush, imem_ack, imem_rdata, inst_ready,
        output pc_o, imem_req, imem_addr, inst_o, inst_valid, misalign_err, fetch_err
    );

    modport slave (
        output npc_i, pc_we, flush, imem_ack, imem_rdata, inst_ready,
        input  pc_o, imem_req, imem_addr, inst_o, inst_valid, misalign_err, fetch_err
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   PC register and instruction-fetch sequencer for the multi-cycle MIPS core.
//   Holds the architectural PC, fetches one word per PC over a req/ack bus and
//   hands the word to decode over valid/ready.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - pc_fetch_if.master (npc_i/pc_we/flush in, pc_o out,
//             imem_req/imem_addr/imem_ack/imem_rdata, inst_o/inst_valid/
//             inst_ready, misalign_err, fetch_err)
//   Optional feature: define FETCH_TIMEOUT_EN to enable the fetch timeout
//   (fetch_err pulse, one-cycle request drop, re-request of the same address).
//   Without it fetch_err is constant 0 and a fetch waits for ack forever.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_3000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_fetch_if.master bus
);

    typedef enum logic [2:0] {
        S_BOOT, S_REQ, S_VALID, S_WAIT_NPC, S_DRAIN
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_q, inst_q;
    logic        pend_q;   // PC already loaded while the held instruction waits
    logic        mis_q;
    logic        req, drop, ack_v, pc_load;

    // An ack only counts while a request is actually on the bus.
    assign ack_v   = bus.imem_ack && req;
    // pc_we is honoured only when no fetch is outstanding; flush always wins.
    assign pc_load = (state != S_BOOT) &&
                     (bus.flush || (bus.pc_we && (state == S_VALID || state == S_WAIT_NPC)));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_BOOT;
        else        state <= state_nxt;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT: state_nxt = S_REQ;
            S_REQ: begin
                if (bus.flush)  state_nxt = ack_v ? S_REQ : S_DRAIN;
                else if (ack_v) state_nxt = S_VALID;
            end
            S_DRAIN: begin
                // Stale response is thrown away, then refetch from the new PC.
                if (!bus.flush && ack_v) state_nxt = S_REQ;
            end
            S_VALID: begin
                if (bus.flush) state_nxt = S_REQ;
                else if (bus.inst_ready)
                    state_nxt = (bus.pc_we || pend_q) ? S_REQ : S_WAIT_NPC;
            end
            S_WAIT_NPC: begin
                if (bus.flush || bus.pc_we) state_nxt = S_REQ;
            end
            default: state_nxt = S_BOOT;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        req            = (state == S_REQ || state == S_DRAIN) && !drop;
        bus.imem_req   = req;
        bus.inst_valid = (state == S_VALID);
    end

    assign bus.pc_o         = pc_q;
    assign bus.imem_addr    = pc_q;
    assign bus.inst_o       = inst_q;
    assign bus.misalign_err = mis_q;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            inst_q <= '0;
            pend_q <= 1'b0;
            mis_q  <= 1'b0;
        end else begin
            if (pc_load) pc_q <= {bus.npc_i[31:2], 2'b00};
            mis_q <= pc_load && (bus.npc_i[1:0] != 2'b00);
            // Data returned in the flush cycle belongs to the old PC.
            if (state == S_REQ && ack_v && !bus.flush) inst_q <= bus.imem_rdata;
            pend_q <= (state_nxt == S_VALID) &&
                      (pend_q || (state == S_VALID && bus.pc_we));
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic          drop_q, ferr_q, timeout;

    assign timeout = req && !bus.imem_ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            drop_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (ack_v || timeout || !(state_nxt == S_REQ || state_nxt == S_DRAIN))
                cnt_q <= '0;
            else if (req)
                cnt_q <= cnt_q + 1'b1;
            // Dropping req for one cycle lets memory abandon the old attempt;
            // the same address is re-presented the cycle after.
            drop_q <= timeout;
            ferr_q <= timeout;
        end
    end

    assign drop          = drop_q;
    assign bus.fetch_err = ferr_q;
`else
    assign drop          = 1'b0;
    assign bus.fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic clk;
    logic rst_n;
    bit   chk_en;
    int   n_chk;
    int   n_fail;

    pc_fetch_if bus();

    pc_fetch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks what the fetch unit is doing in plain terms: booting, fetching,
    // draining a stale fetch, holding an instruction for decode, or idle
    // waiting for the next PC.
    typedef struct packed {
        logic        boot, fetching, drain, hold, pend, mis;
        logic [31:0] pc, inst;
    } model_t;

    model_t m;

    function automatic model_t model_next(model_t s, logic pc_we, logic flush, logic ack_raw,
                                          logic ready, logic [31:0] npc, logic [31:0] rdata);
        model_t n;
        logic   ack;
        n   = s;
        ack = ack_raw && (s.fetching || s.drain);
        n.mis = 1'b0;
        if (s.boot) begin
            n.boot = 1'b0;
            n.fetching = 1'b1;
        end else if (flush) begin
            n.pc = {npc[31:2], 2'b00};
            n.mis = (npc[1:0] != 2'b00);
            n.hold = 1'b0;
            n.pend = 1'b0;
            if (s.fetching && !ack) begin
                n.fetching = 1'b0;
                n.drain = 1'b1;
            end else if (!s.drain) begin
                n.fetching = 1'b1;
            end
        end else if (s.fetching) begin
            if (ack) begin
                n.inst = rdata;
                n.fetching = 1'b0;
                n.hold = 1'b1;
            end
        end else if (s.drain) begin
            if (ack) begin
                n.drain = 1'b0;
                n.fetching = 1'b1;
            end
        end else if (s.hold) begin
            if (pc_we) begin
                n.pc = {npc[31:2], 2'b00};
                n.mis = (npc[1:0] != 2'b00);
                n.pend = 1'b1;
            end
            if (ready) begin
                n.hold = 1'b0;
                n.fetching = n.pend;
                n.pend = 1'b0;
            end
        end else if (pc_we) begin
            n.pc = {npc[31:2], 2'b00};
            n.mis = (npc[1:0] != 2'b00);
            n.fetching = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m <= '{boot: 1'b1, fetching: 1'b0, drain: 1'b0, hold: 1'b0, pend: 1'b0,
                   mis: 1'b0, pc: 32'h0000_3000, inst: 32'h0};
        else
            m <= model_next(m, bus.pc_we, bus.flush, bus.imem_ack, bus.inst_ready,
                            bus.npc_i, bus.imem_rdata);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && chk_en) begin
            chk("pc_o",         bus.pc_o,                32'(m.pc));
            chk("imem_addr",    bus.imem_addr,           32'(m.pc));
            chk("imem_req",     32'(bus.imem_req),       32'(m.fetching || m.drain));
            chk("inst_valid",   32'(bus.inst_valid),     32'(m.hold));
            chk("inst_o",       bus.inst_o,              32'(m.inst));
            chk("misalign_err", 32'(bus.misalign_err),   32'(m.mis));
            chk("fetch_err",    32'(bus.fetch_err),      32'h0);
            chk("no_stale_inst", 32'(bus.inst_valid && bus.inst_o == 32'hDEAD_BEEF), 32'h0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        n_chk = 0;
        n_fail = 0;
        chk_en = 1'b0;
        rst_n = 1'b1;
        bus.npc_i = '0;
        bus.pc_we = 1'b0;
        bus.flush = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.inst_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pc_o",       bus.pc_o,              32'h0000_3000);
        chk("rst_imem_req",   32'(bus.imem_req),     32'h0);
        chk("rst_inst_valid", 32'(bus.inst_valid),   32'h0);
        chk("rst_inst_o",     bus.inst_o,            32'h0);
        chk("rst_misalign",   32'(bus.misalign_err), 32'h0);
        chk("rst_fetch_err",  32'(bus.fetch_err),    32'h0);
        step(); step();
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("boot_no_req", 32'(bus.imem_req), 32'h0);

        // First fetch, ack two cycles after req.
        step();
        chk("t1_req",  32'(bus.imem_req), 32'h1);
        chk("t1_addr", bus.imem_addr,     32'h0000_3000);
        step();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h2408_0005;
        step();
        bus.imem_ack = 1'b0;
        chk("t1_valid", 32'(bus.inst_valid), 32'h1);
        chk("t1_inst",  bus.inst_o,          32'h2408_0005);

        // Accept, then the next PC arrives.
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        chk("t2_wait_valid", 32'(bus.inst_valid), 32'h0);
        chk("t2_wait_req",   32'(bus.imem_req),   32'h0);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678;  // ignored outside a fetch
        step();
        bus.imem_ack = 1'b0;
        bus.pc_we = 1'b1; bus.npc_i = 32'h0000_3004;
        step();
        bus.pc_we = 1'b0;
        chk("t2_pc",   bus.pc_o,          32'h0000_3004);
        chk("t2_req",  32'(bus.imem_req), 32'h1);
        chk("t2_addr", bus.imem_addr,     32'h0000_3004);

        // Accept and load in the same cycle: straight back to a request.
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h8C09_0000;
        step();
        bus.imem_ack = 1'b0;
        chk("t3_inst", bus.inst_o, 32'h8C09_0000);
        bus.inst_ready = 1'b1; bus.pc_we = 1'b1; bus.npc_i = 32'h0000_3040;
        step();
        bus.inst_ready = 1'b0; bus.pc_we = 1'b0;
        chk("t3_req",   32'(bus.imem_req),   32'h1);
        chk("t3_addr",  bus.imem_addr,       32'h0000_3040);
        chk("t3_valid", 32'(bus.inst_valid), 32'h0);

        // Flush during a fetch with no ack: stale response is drained.
        bus.flush = 1'b1; bus.npc_i = 32'h0000_3100;
        step();
        bus.flush = 1'b0;
        chk("t4_pc",  bus.pc_o,          32'h0000_3100);
        chk("t4_req", 32'(bus.imem_req), 32'h1);
        step(); step();
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        bus.imem_ack = 1'b0;
        chk("t4_valid_after_drain", 32'(bus.inst_valid), 32'h0);
        chk("t4_refetch_req",       32'(bus.imem_req),   32'h1);
        chk("t4_refetch_addr",      bus.imem_addr,       32'h0000_3100);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hAC0A_0004;
        step();
        bus.imem_ack = 1'b0;
        chk("t4_inst", bus.inst_o, 32'hAC0A_0004);

        // Misaligned load while decode stalls: instruction retained.
        bus.pc_we = 1'b1; bus.npc_i = 32'h0000_3006;
        step();
        bus.pc_we = 1'b0;
        chk("t5_pc",       bus.pc_o,              32'h0000_3004);
        chk("t5_mis",      32'(bus.misalign_err), 32'h1);
        chk("t5_retained", bus.inst_o,            32'hAC0A_0004);
        chk("t5_valid",    32'(bus.inst_valid),   32'h1);
        step();
        chk("t5_mis_end",  32'(bus.misalign_err), 32'h0);
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        chk("t5_req",  32'(bus.imem_req), 32'h1);
        chk("t5_addr", bus.imem_addr,     32'h0000_3004);

        // Asynchronous reset in the middle of an outstanding fetch.
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_pc",  bus.pc_o,          32'h0000_3000);
        chk("t6_rst_req", 32'(bus.imem_req), 32'h0);
        step();
        rst_n = 1'b1;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1111_1111;  // ack in BOOT is ignored
        step();
        bus.imem_ack = 1'b0;
        chk("t6_req", 32'(bus.imem_req), 32'h1);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h3C01_0001;
        step();
        bus.imem_ack = 1'b0;
        chk("t6_inst", bus.inst_o, 32'h3C01_0001);

        // Flush from VALID, then flush coinciding with ack.
        bus.flush = 1'b1; bus.npc_i = 32'h0000_3200;
        step();
        bus.flush = 1'b0;
        chk("t7_valid", 32'(bus.inst_valid), 32'h0);
        chk("t7_addr",  bus.imem_addr,       32'h0000_3200);
        bus.flush = 1'b1; bus.npc_i = 32'h0000_3300;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h5555_5555;
        step();
        bus.flush = 1'b0; bus.imem_ack = 1'b0;
        chk("t7_ack_flush_valid", 32'(bus.inst_valid), 32'h0);
        chk("t7_ack_flush_addr",  bus.imem_addr,       32'h0000_3300);
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h6666_6666;
        step();
        bus.imem_ack = 1'b0;
        chk("t7_inst", bus.inst_o, 32'h6666_6666);
        step(); step();

`ifdef FETCH_TIMEOUT_EN
        // Withhold ack: 16 request cycles, then one dropped cycle with fetch_err.
        chk_en = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        begin
            int req_cycles;
            int budget;
            req_cycles = 0;
            budget = 0;
            step();
            while (bus.imem_req && budget < 40) begin
                req_cycles++;
                budget++;
                step();
            end
            chk("to_req_cycles", 32'(req_cycles),       32'd16);
            chk("to_fetch_err",  32'(bus.fetch_err),    32'h1);
            chk("to_req_drop",   32'(bus.imem_req),     32'h0);
            step();
            chk("to_rereq",      32'(bus.imem_req),     32'h1);
            chk("to_rereq_addr", bus.imem_addr,         32'h0000_3000);
            chk("to_err_end",    32'(bus.fetch_err),    32'h0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
